// File: rtl/alu_pkg.sv
// Shared ALU definitions: func encodings, driver FSM state codes and the
// DW-bit reference ALU function used by the optional result checker.
package alu_pkg;

  localparam int ALU_DW = 8;
  localparam int ALU_FW = 3;

  typedef enum logic [ALU_FW-1:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_NOT_A = 3'd5,
    ALU_SHL   = 3'd6,
    ALU_SHR   = 3'd7
  } alu_func_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Carries and borrows fall off the top; shifts move by one bit.
  function automatic logic [ALU_DW-1:0] alu_ref(input logic [ALU_DW-1:0] a,
                                                input logic [ALU_DW-1:0] b,
                                                input logic [ALU_FW-1:0] func);
    logic [ALU_DW-1:0] r;
    case (alu_func_e'(func))
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_NOT_A: r = ~a;
      ALU_SHL:   r = a << 1;
      ALU_SHR:   r = a >> 1;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with fall-through head; full/empty are resolved
// from an extra pointer MSB so all DEPTH entries are usable.
module alu_cmd_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_reg;
  logic [AW:0]  rptr_reg;

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr_reg[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push && !full) wptr_reg <= wptr_reg + 1'b1;
      if (pop && !empty) rptr_reg <= rptr_reg + 1'b1;
    end
  end

  assign rdata = mem[rptr_reg[AW-1:0]];
  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[AW] != rptr_reg[AW]) &&
                 (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands, drives registered operands, samples c after ALU_LAT
// cycles and returns it on a valid/ready port. Optional checker: ALU_CHK_EN.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int FW      = 3,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [FW-1:0] cmd_func,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [FW-1:0] alu_func,
  input  logic [DW-1:0] alu_c,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_c,
  output logic [FW-1:0] rsp_func,
  output logic          rsp_err,
  output logic [7:0]    err_cnt,
  output logic          busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  logic [1:0]      state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            run_reg;
  logic [DW-1:0]   alu_a_reg, alu_b_reg, rsp_c_reg;
  logic [FW-1:0]   alu_func_reg, rsp_func_reg;
  logic            rsp_valid_reg;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*DW+FW-1:0] fifo_rdata;
  logic              capture;

  assign cmd_ready = run_reg && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  // A pop happens from IDLE, or on the response handshake for back-to-back issue.
  assign fifo_pop  = !fifo_empty &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_RESP && rsp_ready));
  assign capture   = (state_reg == ST_WAIT) && (cnt_reg == '0);

  alu_cmd_fifo #(.W(2*DW+FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({cmd_a, cmd_b, cmd_func}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      run_reg       <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_func_reg  <= '0;
      rsp_c_reg     <= '0;
      rsp_func_reg  <= '0;
      rsp_valid_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (fifo_pop) begin
        {alu_a_reg, alu_b_reg, alu_func_reg} <= fifo_rdata;
        cnt_reg <= CNT_INIT;
      end
      case (state_reg)
        ST_IDLE: if (!fifo_empty) state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            rsp_c_reg     <= alu_c;
            rsp_func_reg  <= alu_func_reg;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= fifo_empty ? ST_IDLE : ST_WAIT;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_func  = alu_func_reg;
  assign rsp_c     = rsp_c_reg;
  assign rsp_func  = rsp_func_reg;
  assign rsp_valid = rsp_valid_reg;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

`ifdef ALU_CHK_EN
  logic       rsp_err_reg;
  logic [7:0] err_cnt_reg;
  logic       mismatch;

  assign mismatch = (alu_c != alu_ref(alu_a_reg, alu_b_reg, alu_func_reg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else if (capture) begin
      rsp_err_reg <= mismatch;
      if (mismatch && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign rsp_err = rsp_err_reg;
  assign err_cnt = err_cnt_reg;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign rsp_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomized and directed bench for alu_cmd_driver with an ALU stub and a
// queue-based expected-result model. Error-injection case needs ALU_CHK_EN.
module tb_alu_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_func;
  logic [7:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_func;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_c;
  logic [2:0] rsp_func;
  logic       rsp_err;
  logic [7:0] err_cnt;
  logic       busy;
  logic       corrupt_en;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_driver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_func(rsp_func),
    .rsp_err(rsp_err), .err_cnt(err_cnt), .busy(busy)
  );

  // Reference ALU in plain integer arithmetic.
  function automatic logic [7:0] model(input int a, input int b, input int f);
    int r;
    case (f)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = (a * 2) % 256;
      default: r = a / 2;
    endcase
    return r[7:0];
  endfunction

  function automatic logic is_bad_op(input int a, input int b, input int f);
    return corrupt_en && a == 10 && b == 3 && f == 0;
  endfunction

  assign alu_c = is_bad_op(int'(alu_a), int'(alu_b), int'(alu_func)) ? 8'hFF
               : model(int'(alu_a), int'(alu_b), int'(alu_func));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are observed at the falling edge, where both sides are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        logic [7:0] e;
        e = is_bad_op(int'(cmd_a), int'(cmd_b), int'(cmd_func)) ? 8'hFF
          : model(int'(cmd_a), int'(cmd_b), int'(cmd_func));
        exp_q.push_back({cmd_func, e});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          logic [10:0] x;
          x = exp_q.pop_front();
          chk("rsp_c", int'(rsp_c), int'(x[7:0]));
          chk("rsp_func", int'(rsp_func), int'(x[10:8]));
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    int n;
    cmd_a = a; cmd_b = b; cmd_func = f; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("send_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    if (n >= 20) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    int acc, idx, nres, seen, n;
    int t_res[$];
    logic fire_c, fire_r;

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_func = '0; corrupt_en = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick(); tick();
    chk("rel_cmd_ready", int'(cmd_ready), 1);
    chk("rel_busy", int'(busy), 0);

    // Latency: operands after T1, result after T2.
    send(8'd10, 8'd3, 3'd0);
    chk("t2_busy", int'(busy), 1);
    tick();
    chk("t2_alu_a", int'(alu_a), 10);
    chk("t2_alu_b", int'(alu_b), 3);
    chk("t2_valid_t1", int'(rsp_valid), 0);
    tick();
    chk("t2_valid_t2", int'(rsp_valid), 1);
    chk("t2_rsp_c", int'(rsp_c), 13);
    chk("t2_rsp_func", int'(rsp_func), 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("t2_valid_drop", int'(rsp_valid), 0);

    // Response held under backpressure.
    send(8'd4, 8'd2, 3'd1);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", int'(rsp_valid), 1);
      chk("t3_hold_c", int'(rsp_c), 2);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("t3_valid_drop", int'(rsp_valid), 0);

    // Capacity and back-to-back spacing.
    acc = 0; idx = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_a = 8'(20 + idx); cmd_b = 8'(idx); cmd_func = 3'(idx);
      fire_c = cmd_ready;
      tick();
      if (fire_c) begin acc++; idx++; end
    end
    chk("t4_accepted", acc, 5);
    chk("t4_cmd_ready", int'(cmd_ready), 0);
    rsp_ready = 1'b1; nres = 0; n = 0;
    while (nres < 6 && n < 60) begin
      cmd_a = 8'(20 + idx); cmd_b = 8'(idx); cmd_func = 3'(idx);
      cmd_valid = (idx < 6);
      fire_c = cmd_valid && cmd_ready;
      fire_r = rsp_valid;
      tick();
      if (fire_c) idx++;
      if (fire_r) begin t_res.push_back(n); nres++; end
      n++;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("t4_results", nres, 6);
    for (int i = 1; i < t_res.size(); i++) chk("t4_spacing", t_res[i] - t_res[i-1], 2);

    // Reset during WAIT with three commands queued.
    idx = 0; n = 0;
    while (idx < 5 && n < 20) begin
      cmd_valid = 1'b1; cmd_a = 8'(50 + idx); cmd_b = 8'd1; cmd_func = 3'd3;
      fire_c = cmd_ready;
      tick();
      if (fire_c) idx++;
      n++;
    end
    cmd_valid = 1'b0;
    tick(); tick();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("t5_pre_busy", int'(busy), 1);
    chk("t5_pre_valid", int'(rsp_valid), 0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t5_rst_alu_a", int'(alu_a), 0);
    chk("t5_rst_alu_func", int'(alu_func), 0);
    chk("t5_rst_rsp_c", int'(rsp_c), 0);
    chk("t5_rst_cmd_ready", int'(cmd_ready), 0);
    chk("t5_rst_busy", int'(busy), 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("t5_cmd_ready", int'(cmd_ready), 1);
    chk("t5_busy", int'(busy), 0);
    rsp_ready = 1'b1; seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (rsp_valid) seen++; end
    rsp_ready = 1'b0;
    chk("t5_no_rsp", seen, 0);

`ifdef ALU_CHK_EN
    corrupt_en = 1'b1;
    send(8'd10, 8'd3, 3'd0);
    wait_rsp();
    chk("t6_rsp_c", int'(rsp_c), 8'hFF);
    chk("t6_rsp_err", int'(rsp_err), 1);
    chk("t6_err_cnt", int'(err_cnt), 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    corrupt_en = 1'b0;
    send(8'd5, 8'd6, 3'd2);
    wait_rsp();
    chk("t6_ok_err", int'(rsp_err), 0);
    chk("t6_ok_cnt", int'(err_cnt), 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`else
    chk("t6_rsp_err_tied", int'(rsp_err), 0);
    chk("t6_err_cnt_tied", int'(err_cnt), 0);
`endif

    // Randomized traffic with random backpressure.
    fire_c = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!cmd_valid || fire_c) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_func = 3'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      fire_c = cmd_valid && cmd_ready;
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1; n = 0;
    while ((busy || rsp_valid) && n < 60) begin tick(); n++; end
    chk("drain_busy", int'(busy), 0);
    chk("drain_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
